// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared FSM state type, SPI mode constants and default sizes
//               for the single-byte SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic c_cpol = 1'b0;
    localparam logic c_cpha = 1'b0;

    localparam int c_data_w_default  = 8;
    localparam int c_clk_div_default = 4;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// Module      : spi_sclk_gen
// Description : Half-period counter; pulses tick once every CLK_DIV cycles
//               while enabled and clears whenever disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_cnt_max);
    assign tick   = en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_byte.sv
// ============================================================================
// Module      : spi_master_byte
// Description : Mode-0, MSB-first SPI master transferring one DATA_W-bit word
//               per start request, with sclk derived from clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_byte
    import spi_pkg::*;
#(
    parameter int DATA_W  = c_data_w_default,
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int c_edge_w = $clog2(2 * DATA_W + 1);
    localparam logic [c_edge_w-1:0] c_last_edge  = c_edge_w'(2 * DATA_W);
    localparam logic [c_edge_w-1:0] c_first_edge = c_edge_w'(1);

    state_t              r_state;
    logic [c_edge_w-1:0] r_edge;
    logic [c_edge_w-1:0] w_edge_next;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cs_n;
    logic                r_busy;
    logic                r_done;
    logic                w_tick;
    logic                w_en;

    assign w_en        = (r_state != IDLE);
    assign w_edge_next = r_edge + 1'b1;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_edge    <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_sclk    <= c_cpol;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETUP;
                        r_tx_sr <= tx_data;
                        r_mosi  <= tx_data[DATA_W-1];
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_edge  <= '0;
                    end
                end
                SETUP: begin
                    // First rising edge samples the bit the slave presented
                    // when chip select fell.
                    if (w_tick) begin
                        r_state <= SHIFT;
                        r_sclk  <= ~c_cpol;
                        r_edge  <= c_first_edge;
                        r_rx_sr <= {r_rx_sr[DATA_W-2:0], miso};
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_edge <= w_edge_next;
                        r_sclk <= ~r_sclk;
                        if (w_edge_next[0]) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], miso};
                        end else if (w_edge_next == c_last_edge) begin
                            r_state <= HOLD;
                        end else begin
                            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                            r_mosi  <= r_tx_sr[DATA_W-2];
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_cs_n    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_sr;
                        r_mosi    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_byte.sv
// ============================================================================
// Module      : tb_spi_master_byte
// Description : Scoreboard bench for spi_master_byte at default sizes and at
//               CLK_DIV=1 with start held high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_byte;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, sclk, mosi, miso, cs_n;
    logic [7:0] rx_data;

    logic       rst1;
    logic       start1;
    logic [7:0] tx1;
    logic       busy1, done1, sclk1, mosi1, cs_n1;
    logic [7:0] rx1;

    logic       loop_mode;
    logic [7:0] slave_word;
    int         nfall = 0;
    logic       w_slave_bit;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb[$];
    logic [7:0] sb1[$];

    always #5 clk = ~clk;

    spi_master_byte dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    spi_master_byte #(
        .DATA_W  (8),
        .CLK_DIV (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst1),
        .start   (start1),
        .tx_data (tx1),
        .busy    (busy1),
        .done    (done1),
        .rx_data (rx1),
        .sclk    (sclk1),
        .mosi    (mosi1),
        .miso    (mosi1),
        .cs_n    (cs_n1)
    );

    // Slave model: presents MSB at chip-select fall, advances on falling sclk.
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) nfall <= 0;
        else      nfall <= nfall + 1;
    end

    assign w_slave_bit = (nfall < 8) ? slave_word[3'(7 - nfall)] : 1'b0;
    assign miso        = loop_mode ? mosi : w_slave_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] got);
        if (sb.size() == 0) check({tag, "_sb_empty"}, 32'(got), 32'hDEADBEEF);
        else                check(tag, 32'(got), 32'(sb.pop_front()));
    endtask

    task automatic xfer(input logic [7:0] d, input logic [7:0] exp, input bit slave,
                        input int busy_start_at, input int rst_at);
        int   t;
        int   rises;
        int   bad_rise_t;
        int   bad_mosi;
        int   bad_cs;
        bit   seen_done;
        logic prev_sclk;
        t = 0; rises = 0; bad_rise_t = 0; bad_mosi = 0; bad_cs = 0;
        seen_done = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        tx_data = d;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("cs_fall_t0", 32'(cs_n), 32'd0);
        check("busy_t0", 32'(busy), 32'd1);
        if (!slave) check("mosi_msb_t0", 32'(mosi), 32'(d[7]));
        prev_sclk = sclk;
        while (t < 150 && !seen_done) begin
            @(negedge clk);
            t++;
            if (sclk && !prev_sclk) begin
                rises++;
                if ((t % 8) != 4) bad_rise_t++;
                if (mosi !== 1'b1) bad_mosi++;
            end
            prev_sclk = sclk;
            if (t < 68 && cs_n !== 1'b0) bad_cs++;
            if (done) begin
                seen_done = 1'b1;
                if (rst_at < 0) begin
                    check("done_t", t, 68);
                    check("cs_rise_at_done", 32'(cs_n), 32'd1);
                    check("busy_fall_at_done", 32'(busy), 32'd0);
                    check("sclk_rises", rises, 8);
                    pop_rx("rx_data", rx_data);
                end
            end
            if (rst_at >= 0 && t == rst_at + 1) begin
                rst = 1'b0;
                sb.delete();
                check("rst_cs_n", 32'(cs_n), 32'd1);
                check("rst_sclk", 32'(sclk), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_rx_data", 32'(rx_data), 32'd0);
            end
            if (t == rst_at) rst = 1'b1;
            if (t == busy_start_at) begin
                start   = 1'b1;
                tx_data = 8'h00;
            end else if (t == busy_start_at + 1) begin
                start = 1'b0;
            end
        end
        if (rst_at >= 0) begin
            check("no_done_after_rst", 32'(seen_done), 32'd0);
        end else begin
            if (!seen_done) check("done_timeout", 32'd0, 32'd1);
            check("cs_low_window", bad_cs, 0);
            if (slave) check("mosi_at_rises", bad_mosi, 0);
            else       check("rise_timing", bad_rise_t, 0);
        end
    endtask

    initial begin
        int c, last_done, ndone, highs, last_rise, bad_period, cs_low, extra_done;
        logic prev_cs1, prev_sclk1;
        rst = 1'b1; start = 1'b0; tx_data = 8'h00;
        rst1 = 1'b1; start1 = 1'b0; tx1 = 8'h00;
        loop_mode = 1'b1; slave_word = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_cs_n", 32'(cs_n), 32'd1);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;

        xfer(8'hA5, 8'hA5, 1'b0, -1, -1);

        loop_mode  = 1'b0;
        slave_word = 8'h3C;
        xfer(8'hFF, 8'h3C, 1'b1, -1, -1);
        loop_mode  = 1'b1;

        xfer(8'hA5, 8'hA5, 1'b0, 10, -1);
        cs_low = 0; extra_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (cs_n !== 1'b1) cs_low++;
            if (done) extra_done++;
        end
        check("no_second_cs_low", cs_low, 0);
        check("no_second_done", extra_done, 0);

        xfer(8'hC3, 8'hC3, 1'b0, -1, 30);
        xfer(8'h5A, 8'h5A, 1'b0, -1, -1);

        // CLK_DIV=1 back-to-back run with start held high
        @(negedge clk);
        rst1 = 1'b0;
        repeat (4) sb1.push_back(8'h96);
        tx1 = 8'h96; start1 = 1'b1;
        c = 0; last_done = -1; ndone = 0; highs = 0; last_rise = -1; bad_period = 0;
        prev_cs1 = 1'b1; prev_sclk1 = 1'b0;
        while (c < 200 && ndone < 4) begin
            @(negedge clk);
            c++;
            if (sclk1 && !prev_sclk1) begin
                if (last_rise >= 0 && (c - last_rise) != 2) bad_period++;
                last_rise = c;
            end
            prev_sclk1 = sclk1;
            if (done1) begin
                if (last_done >= 0) check("done_period_div1", c - last_done, 18);
                last_done = c;
                ndone++;
                last_rise = -1;
                check("busy_div1_at_done", 32'(busy1), 32'd0);
                if (sb1.size() == 0) check("rx_div1_sb_empty", 32'(rx1), 32'hDEADBEEF);
                else                 check("rx_div1", 32'(rx1), 32'(sb1.pop_front()));
            end
            if (cs_n1 && ndone > 0) highs++;
            if (!cs_n1 && prev_cs1 && ndone > 0) begin
                check("cs_high_gap_div1", highs, 1);
                highs = 0;
            end
            prev_cs1 = cs_n1;
        end
        start1 = 1'b0;
        check("dones_div1", ndone, 4);
        check("sclk_period_div1", bad_period, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
